// File: rtl/tpumac_pe_if.sv
// tpumac_pe_if: operand/accumulator bundle of one systolic MAC processing element.
//   master : the array fabric (drives en, WrEn, Ain, Bin, Cin; observes the outputs)
//   slave  : the processing element (tpumac_pe)
// Signals:
//   en        global advance; every PE register holds while low
//   WrEn      load Cin into the accumulator (qualified by en)
//   Ain, Bin  signed operands (BITS_AB)
//   Cin       signed accumulator load value (BITS_C)
//   Aout,Bout registered operands forwarded east/south
//   Cout      accumulator
//   ovf       sticky overflow flag
interface tpumac_pe_if #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
);
  logic                      en;
  logic                      WrEn;
  logic signed [BITS_AB-1:0] Ain;
  logic signed [BITS_AB-1:0] Bin;
  logic signed [BITS_C-1:0]  Cin;
  logic signed [BITS_AB-1:0] Aout;
  logic signed [BITS_AB-1:0] Bout;
  logic signed [BITS_C-1:0]  Cout;
  logic                      ovf;

  modport master (
    output en, WrEn, Ain, Bin, Cin,
    input  Aout, Bout, Cout, ovf
  );

  modport slave (
    input  en, WrEn, Ain, Bin, Cin,
    output Aout, Bout, Cout, ovf
  );
endinterface

// File: rtl/tpumac_pe.sv
// tpumac_pe: parametrised systolic multiply-accumulate processing element.
// A is forwarded east, B south, and the partial sum C is held locally.
// Ports:
//   clk    single clock
//   rst_n  asynchronous active-low reset
//   bus    tpumac_pe_if.slave (en, WrEn, Ain, Bin, Cin in; Aout, Bout, Cout, ovf out)
// Parameters:
//   BITS_AB  operand width (signed)
//   BITS_C   accumulator width (signed), BITS_C >= 2*BITS_AB
//   MUL_PIPE 0: combinational product, 1: registered product stage
// Build option:
//   TPUMAC_SAT_EN  when defined, accumulation saturates on overflow;
//                  otherwise it wraps. ovf behaves the same in both builds.
module tpumac_pe #(
  parameter int BITS_AB  = 8,
  parameter int BITS_C   = 16,
  parameter int MUL_PIPE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  tpumac_pe_if.slave bus
);

  if (BITS_C < 2*BITS_AB) begin : g_bad_bits_c
    $error("tpumac_pe: BITS_C must be at least 2*BITS_AB");
  end
  if (MUL_PIPE != 0 && MUL_PIPE != 1) begin : g_bad_mul_pipe
    $error("tpumac_pe: MUL_PIPE must be 0 or 1");
  end

  // Resolves the BITS_C+1 bit sum to the stored accumulator value.
  function automatic logic signed [BITS_C-1:0] acc_fn(input logic signed [BITS_C:0] s);
`ifdef TPUMAC_SAT_EN
    if (s[BITS_C] != s[BITS_C-1])
      return s[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
    else
      return s[BITS_C-1:0];
`else
    return s[BITS_C-1:0];
`endif
  endfunction

  // ---- stage p0: full-width signed product of the incoming operands ----
  logic signed [2*BITS_AB-1:0] prod_p0;
  logic signed [2*BITS_AB-1:0] acc_opnd;
  logic                        acc_go;
  logic signed [BITS_C:0]      sum;
  logic                        ovf_now;

  assign prod_p0 = bus.Ain * bus.Bin;

  // ---- stage p1: optional product register ----
  if (MUL_PIPE == 1) begin : g_pipe
    logic signed [2*BITS_AB-1:0] prod_p1;
    logic                        vld_p1;

    // A load clears vld_p1 so the product captured alongside it is never added.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_p1 <= '0;
        vld_p1  <= 1'b0;
      end else if (bus.en) begin
        prod_p1 <= prod_p0;
        vld_p1  <= !bus.WrEn;
      end
    end

    assign acc_opnd = prod_p1;
    assign acc_go   = vld_p1;
  end else begin : g_comb
    assign acc_opnd = prod_p0;
    assign acc_go   = 1'b1;
  end

  // ---- accumulate: one guard bit exposes signed overflow ----
  assign sum     = (BITS_C+1)'(bus.Cout) + (BITS_C+1)'(acc_opnd);
  assign ovf_now = sum[BITS_C] ^ sum[BITS_C-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Aout <= '0;
      bus.Bout <= '0;
      bus.Cout <= '0;
      bus.ovf  <= 1'b0;
    end else if (bus.en) begin
      bus.Aout <= bus.Ain;
      bus.Bout <= bus.Bin;
      if (bus.WrEn) begin
        bus.Cout <= bus.Cin;
        bus.ovf  <= 1'b0;
      end else if (acc_go) begin
        bus.Cout <= acc_fn(sum);
        if (ovf_now) bus.ovf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tpumac_pe.md
# tpumac_pe

Parametrised systolic multiply-accumulate processing element, the next generation of the fixed 8/16-bit `tpumac` cell. It is tiled into the TPU systolic array: A flows east, B flows south, and the partial sum C is held locally. It adds configurable operand and accumulator widths, an optional registered multiplier stage, an in-flight-product discard on load, a sticky overflow flag, and compile-time saturating accumulation.

## Interface

Parameters:
- `BITS_AB`, 8, signed width of the A and B operands.
- `BITS_C`, 16, signed accumulator width. Must satisfy `BITS_C >= 2*BITS_AB`; an elaboration-time `$error` fires otherwise.
- `MUL_PIPE`, 0, 0 means combinational product; 1 means a registered product stage. No other values are legal.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: global advance. When it is 0, every register holds.
- `WrEn` in 1: load `Cin` into the accumulator. It is qualified by `en`.
- `Ain` in `BITS_AB`: signed A operand.
- `Bin` in `BITS_AB`: signed B operand.
- `Cin` in `BITS_C`: signed accumulator load value.
- `Aout` out `BITS_AB`: registered `Ain`, forwarded to the neighbour.
- `Bout` out `BITS_AB`: registered `Bin`, forwarded to the neighbour.
- `Cout` out `BITS_C`: accumulator.
- `ovf` out 1: sticky overflow flag.

## Operation

- **Reset (async, `rst_n`=0):** `Aout`, `Bout`, `Cout`, `ovf`, the product register `P` and the product-valid bit `pv` are all 0.
- **`en`=0:** all state holds, including `P` and `pv`. `WrEn` is ignored.
- **`en`=1, every cycle:** `Aout<=Ain` and `Bout<=Bin`.
- **Product:** `Ain*Bin` is a full `2*BITS_AB` signed product, sign-extended to `BITS_C`. The sum is formed at `BITS_C+1` bits.
- **`MUL_PIPE`=0, `en`=1:**
  - With `WrEn`=1: `Cout<=Cin` and `ovf<=0`.
  - Otherwise: `Cout<=acc(Cout, Ain*Bin)`.
- **`MUL_PIPE`=1, `en`=1:**
  - `P<=Ain*Bin` every enabled cycle.
  - With `WrEn`=1: `Cout<=Cin`, `ovf<=0` and `pv<=0`. Any in-flight product is discarded.
  - Otherwise: `pv<=1`, and if `pv`=1 then `Cout<=acc(Cout, P)`.
- **`acc(x, p)`:** `x+p` truncated to `BITS_C`, or saturated (see Configuration).
- **Overflow:** detected when the `BITS_C+1`-bit sum falls outside the signed `BITS_C` range. It sets `ovf`=1, which holds until the next `WrEn` or reset.
- **Simultaneous events:** `WrEn` wins over accumulation. Overflow on a load cycle is impossible, so on that cycle `ovf` goes to 0.
- **Reset mid-accumulation:** takes effect immediately. `pv`=0, so no stale product is added after release.

## Timing

- `Aout`/`Bout` latency: 1 enabled edge, independent of `MUL_PIPE`.
- `Cout` load latency: 1 enabled edge.
- `Cout` accumulate latency: 1 enabled edge when `MUL_PIPE`=0, 2 enabled edges when `MUL_PIPE`=1. Disabled cycles do not count.
- `ovf` updates on the same edge as the `Cout` it describes.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

- **`TPUMAC_SAT_EN` defined:** on overflow, `Cout` clamps to `2^(BITS_C-1)-1` for positive overflow or `-2^(BITS_C-1)` for negative overflow.
- **`TPUMAC_SAT_EN` undefined:** `Cout` wraps (two's-complement truncation).
- `ovf` behaviour is identical in both builds.

## Test plan

Default parameters unless stated.

1. **Reset.** `Ain`=0x55, `Bin`=0xFF, `Cin`=0x00F0, `rst_n`=0 for 2 cycles → `Aout`=`Bout`=0x00, `Cout`=0x0000, `ovf`=0. Assert reset again mid-accumulation → outputs go to 0 without waiting for an edge.
2. **Load.** `rst_n`=1, `en`=1, `WrEn`=1, one edge → `Aout`=0x55, `Bout`=0xFF, `Cout`=0x00F0.
3. **Accumulate.** From `Cout`=0x00F0, `WrEn`=0, `Ain`=0x55 (85), `Bin`=0xFF (-1) → `Cout`=0x009B after 1 edge (`MUL_PIPE`=0) or after 2 edges (`MUL_PIPE`=1). Then hold `en`=0 for 5 cycles → all outputs unchanged.
4. **Positive overflow.** Load 0x7F00, then `Ain`=`Bin`=0x7F (+0x3F01) → `ovf`=1 and `Cout`=0x7FFF with `TPUMAC_SAT_EN`, 0xBE01 without. Next `WrEn` → `ovf`=0.
5. **Negative overflow.** Load 0x8000, then `Ain`=0x80, `Bin`=0x7F (-16256) → `ovf`=1 and `Cout`=0x8000 with `TPUMAC_SAT_EN`, 0x4080 without.
6. **Pipeline discard (`MUL_PIPE`=1).** Accumulate edge with `Ain`=0x10, `Bin`=0x10, followed immediately by `WrEn`=1 with `Cin`=0x0005 → `Cout`=0x0005. With `Ain`=`Bin`=0 afterwards, `Cout` stays 0x0005: the 0x0100 product is never added.
